// File: rtl/lc3p_pkg.sv
// Shared definitions for the LC-3 style core: opcodes, control states, sign extension.
package lc3p_pkg;

    localparam logic [3:0] OpBr   = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpLd   = 4'h2;
    localparam logic [3:0] OpSt   = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h5;
    localparam logic [3:0] OpNot  = 4'h9;
    localparam logic [3:0] OpJmp  = 4'hC;
    localparam logic [3:0] OpLea  = 4'hE;
    localparam logic [3:0] OpTrap = 4'hF;

    // Widest datapath supported by sext; callers truncate to DATA_W.
    localparam int unsigned MaxW = 64;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StHalt
    } state_e;

    function automatic logic [MaxW-1:0] sext(input logic [15:0] val, input int unsigned bits);
        logic [MaxW-1:0] res;
        logic [3:0]      idx;
        for (int unsigned i = 0; i < MaxW; i++) begin
            idx    = (i < bits) ? 4'(i) : 4'(bits - 1);
            res[i] = val[idx];
        end
        return res;
    endfunction

endpackage

// File: rtl/lc3p_if.sv
// Single-port memory handshake: request held until ack, ack may arrive in the first cycle.
interface lc3p_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lc3p_regfile.sv
// Eight-entry register file: two combinational read ports, one clocked write port.
module lc3p_regfile #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        ra1_i,
    output logic [DATA_W-1:0] rd1_o,
    input  logic [2:0]        ra2_i,
    output logic [DATA_W-1:0] rd2_o,
    input  logic              we_i,
    input  logic [2:0]        wa_i,
    input  logic [DATA_W-1:0] wd_i
);
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];

    always_comb begin
        regs_d = regs_q;
        if (we_i) regs_d[wa_i] = wd_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1_o = regs_q[ra1_i];
    assign rd2_o = regs_q[ra2_i];
endmodule

// File: rtl/lc3p_core.sv
// Self-sequenced LC-3 subset core: fetch/decode/execute FSM around a register file,
// ALU and effective-address adder, talking to memory through a req/ack handshake.
module lc3p_core
    import lc3p_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = 'h3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    lc3p_if.master            mem,
    output logic [15:0]       IR,
    output logic [ADDR_W-1:0] PC,
    output logic              N,
    output logic              Z,
    output logic              P,
    output logic              halted,
    output logic              illegal
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              n_q, n_d, z_q, z_d, p_q, p_d;
    logic              halted_q, halted_d, illegal_q, illegal_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [3:0]        opcode;
    logic [2:0]        ra2;
    logic [DATA_W-1:0] rd1, rd2, off9, imm5, ea, alu_b, alu_res;
    logic              rf_we, flag_we, br_taken;
    logic [DATA_W-1:0] rf_wdata;

    assign opcode   = ir_q[15:12];
    // ST reads its source register through port 2 so the write data is ready in DECODE.
    assign ra2      = (opcode == OpSt) ? ir_q[11:9] : ir_q[2:0];
    assign off9     = DATA_W'(sext(ir_q, 9));
    assign imm5     = DATA_W'(sext(ir_q, 5));
    assign ea       = DATA_W'(pc_q) + off9;
    assign alu_b    = ir_q[5] ? imm5 : rd2;
    assign br_taken = (ir_q[11] & n_q) | (ir_q[10] & z_q) | (ir_q[9] & p_q);

    always_comb begin
        case (opcode)
            OpAdd:   alu_res = rd1 + alu_b;
            OpAnd:   alu_res = rd1 & alu_b;
            default: alu_res = ~rd1;
        endcase
    end

    lc3p_regfile #(
        .DATA_W(DATA_W)
    ) u_regfile (
        .clk  (clk),
        .reset(reset),
        .ra1_i(ir_q[8:6]),
        .rd1_o(rd1),
        .ra2_i(ra2),
        .rd2_o(rd2),
        .we_i (rf_we),
        .wa_i (ir_q[11:9]),
        .wd_i (rf_wdata)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rf_we     = 1'b0;
        rf_wdata  = alu_res;
        flag_we   = 1'b0;

        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc_q;
                end
            end
            StFetch: begin
                if (mem.mem_ack) begin
                    ir_d    = mem.mem_rdata[15:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    req_d   = 1'b0;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (opcode)
                    OpLd, OpSt: begin
                        state_d = StMem;
                        req_d   = 1'b1;
                        we_d    = (opcode == OpSt);
                        addr_d  = ea[ADDR_W-1:0];
                        if (opcode == OpSt) wdata_d = rd2;
                    end
                    OpTrap: begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
                    OpBr, OpAdd, OpAnd, OpNot, OpJmp, OpLea: state_d = StExec;
                    default: begin
                        state_d   = StHalt;
                        halted_d  = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StExec: begin
                case (opcode)
                    OpAdd, OpAnd, OpNot: begin
                        rf_we   = 1'b1;
                        flag_we = 1'b1;
                    end
                    OpBr:  if (br_taken) pc_d = ea[ADDR_W-1:0];
                    OpJmp: pc_d = rd1[ADDR_W-1:0];
                    OpLea: begin
                        rf_we    = 1'b1;
                        rf_wdata = ea;
                    end
                    default: ;
                endcase
                state_d = StFetch;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = pc_d;
            end
            StMem: begin
                if (mem.mem_ack) begin
                    if (opcode == OpLd) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem.mem_rdata;
                        flag_we  = 1'b1;
                    end
                    // Back-to-back: the next fetch request starts right after the ack.
                    state_d = StFetch;
                    we_d    = 1'b0;
                    addr_d  = pc_q;
                end
            end
            StHalt:  ;
            default: state_d = StIdle;
        endcase

        n_d = n_q;
        z_d = z_q;
        p_d = p_q;
        if (flag_we) begin
            n_d = rf_wdata[DATA_W-1];
            z_d = (rf_wdata == '0);
            p_d = ~n_d & ~z_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b1;
            p_q       <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            n_q       <= n_d;
            z_q       <= z_d;
            p_q       <= p_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign IR            = ir_q;
    assign PC            = pc_q;
    assign N             = n_q;
    assign Z             = z_q;
    assign P             = p_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;
endmodule

// File: tb/tb_lc3p_core.sv
// Directed bench for lc3p_core: program table stepped per instruction plus handshake corners.
module tb_lc3p_core;
    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        n, z, p, halted, illegal;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [0:65535];
    int unsigned wait_rd, wait_wr, cnt;

    lc3p_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    lc3p_core #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .PC_RESET(16'h3000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .mem    (bus),
        .IR     (ir),
        .PC     (pc),
        .N      (n),
        .Z      (z),
        .P      (p),
        .halted (halted),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = ram[bus.mem_addr];
    assign bus.mem_ack   = bus.mem_req && (cnt >= (bus.mem_we ? wait_wr : wait_rd));

    always @(posedge clk or posedge reset) begin
        if (reset) cnt <= 0;
        else if (!bus.mem_req || bus.mem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_we && bus.mem_ack) ram[bus.mem_addr] = bus.mem_wdata;
    end

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [2:0]  nzp;
        int          rix;
        logic [15:0] rval;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic start();
        reset   = 1'b1;
        run     = 1'b0;
        wait_rd = 0;
        wait_wr = 0;
        for (int i = 0; i < 65536; i++) ram[i] = 16'hD000;
        #1;
    endtask

    task automatic go();
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;
        tick(1);
    endtask

    initial begin
        vecs[0]  = '{16'h3000, 16'h1262, 16'h3001, 3'b001, 1, 16'h0002};
        vecs[1]  = '{16'h3001, 16'h54A0, 16'h3002, 3'b010, 2, 16'h0000};
        vecs[2]  = '{16'h3002, 16'h0005, 16'h3003, 3'b010, 2, 16'h0000};
        vecs[3]  = '{16'h3003, 16'h14BF, 16'h3004, 3'b100, 2, 16'hFFFF};
        vecs[4]  = '{16'h3004, 16'h9A7F, 16'h3005, 3'b100, 5, 16'hFFFD};
        vecs[5]  = '{16'h3005, 16'h1C45, 16'h3006, 3'b100, 6, 16'hFFFF};
        vecs[6]  = '{16'h3006, 16'h1FA1, 16'h3007, 3'b010, 7, 16'h0000};
        vecs[7]  = '{16'h3007, 16'h5781, 16'h3008, 3'b001, 3, 16'h0002};
        vecs[8]  = '{16'h3008, 16'hE803, 16'h3009, 3'b001, 4, 16'h300C};
        vecs[9]  = '{16'h3009, 16'h0202, 16'h300C, 3'b001, 4, 16'h300C};
        vecs[10] = '{16'h300C, 16'h3605, 16'h300D, 3'b001, 3, 16'h0002};
        vecs[11] = '{16'h300D, 16'h2004, 16'h300E, 3'b001, 0, 16'h0002};
        vecs[12] = '{16'h300E, 16'h2611, 16'h300F, 3'b100, 3, 16'h8000};
        vecs[13] = '{16'h300F, 16'hE808, 16'h3010, 3'b100, 4, 16'h3018};
        vecs[14] = '{16'h3010, 16'hC100, 16'h3018, 3'b100, 4, 16'h3018};
        vecs[15] = '{16'h3018, 16'h0801, 16'h301A, 3'b100, 3, 16'h8000};

        // Reset state and main program, run dropped after leaving IDLE.
        start();
        check("rst_pc", pc, 16'h3000);
        check("rst_ir", ir, 16'h0000);
        check("rst_nzp", {n, z, p}, 3'b010);
        check("rst_halt", {halted, illegal}, 2'b00);
        check("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 34'h0);
        for (int i = 0; i < 16; i++) ram[vecs[i].addr] = vecs[i].instr;
        ram[16'h3020] = 16'h8000;
        ram[16'h301A] = 16'hF025;
        go();
        run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(3);
            check($sformatf("v%0d_ir", i), ir, vecs[i].instr);
            check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            check($sformatf("v%0d_nzp", i), {n, z, p}, vecs[i].nzp);
            check($sformatf("v%0d_r%0d", i, vecs[i].rix),
                  dut.u_regfile.regs_q[vecs[i].rix], vecs[i].rval);
        end
        check("st_ram", ram[16'h3012], 16'h0002);
        run = 1'b1;
        tick(2);
        check("trap_halt", {halted, illegal}, 2'b10);
        tick(5);
        check("trap_sticky", {halted, bus.mem_req}, 2'b10);
        check("trap_pc", pc, 16'h301B);

        // BRz taken / BRn not taken after AND zero.
        start();
        ram[16'h3000] = 16'h54A0;
        ram[16'h3001] = 16'h0402;
        go();
        tick(6);
        check("brz_pc", pc, 16'h3004);
        check("brz_z", {n, z, p}, 3'b010);
        start();
        ram[16'h3000] = 16'h54A0;
        ram[16'h3001] = 16'h0802;
        go();
        tick(6);
        check("brn_pc", pc, 16'h3002);

        // ST with four wait states: request must stay stable until the ack.
        start();
        ram[16'h3000] = 16'h1262;
        ram[16'h3001] = 16'h3205;
        wait_wr = 4;
        go();
        tick(3);
        tick(2);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stw%0d_bus", k), {bus.mem_req, bus.mem_we, bus.mem_addr},
                  {2'b11, 16'h3007});
            check($sformatf("stw%0d_wd", k), bus.mem_wdata, 16'h0002);
            tick(1);
        end
        check("stw_next", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 16'h3002});
        check("stw_pc", pc, 16'h3002);
        check("stw_ram", ram[16'h3007], 16'h0002);

        // Illegal opcode.
        start();
        ram[16'h3000] = 16'hD000;
        go();
        tick(2);
        check("ill_halt", {halted, illegal, bus.mem_req}, 3'b110);

        // Reset asserted during a stalled fetch.
        start();
        ram[16'h3000] = 16'h1262;
        go();
        tick(3);
        wait_rd = 5;
        tick(2);
        check("rf_pre", {bus.mem_req, bus.mem_addr, ir}, {1'b1, 16'h3001, 16'h1262});
        #2;
        reset = 1'b1;
        #1;
        check("rf_req", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 34'h0);
        check("rf_pc_ir", {pc, ir}, {16'h3000, 16'h0000});
        check("rf_flags", {n, z, p, halted, illegal}, 5'b01000);
        check("rf_r1", dut.u_regfile.regs_q[1], 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
